// File: rtl/nios_system_gpio_bidir_irq.sv
// Avalon-MM bidirectional GPIO: per-pin direction, atomic set/clear, 2-flop input
// synchroniser, selectable edge capture (write-1-to-clear) and a maskable IRQ.
module nios_system_gpio_bidir_irq #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      EDGE_TYPE = 0,
  parameter int unsigned      IRQ_TYPE  = 1,
  parameter logic [WIDTH-1:0] RESET_OUT = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] sync0_q, sync1_q, prev_q;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr;
  logic [WIDTH-1:0] wd, clr, rise, fall, edge_det, irq_src;
  logic             unused_wd;

  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
  end

  always_comb begin
    wr         = chipselect & ~write_n;
    wd         = writedata[WIDTH-1:0];
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    clr        = '0;
    if (wr) begin
      case (address)
        3'd0:    data_out_d = wd;
        3'd1:    dir_d      = wd;
        3'd2:    mask_d     = wd;
        3'd3:    clr        = wd;
        3'd4:    data_out_d = data_out_q | wd;
        3'd5:    data_out_d = data_out_q & ~wd;
        default: ;
      endcase
    end

    rise = sync1_q & ~prev_q;
    fall = ~sync1_q & prev_q;
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
    // A new edge beats a same-cycle clear so no event is lost.
    edgecap_d = (edgecap_q & ~clr) | edge_det;

    irq_src = (IRQ_TYPE == 0) ? sync1_q : edgecap_q;
    irq_d   = |(irq_src & mask_q);

    case (address)
      3'd0:    readdata_d = 32'(sync1_q);
      3'd1:    readdata_d = 32'(dir_q);
      3'd2:    readdata_d = 32'(mask_q);
      3'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT;
      dir_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      sync0_q    <= '0;
      sync1_q    <= '0;
      prev_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      sync0_q    <= bidir_port;
      sync1_q    <= sync0_q;
      prev_q     <= sync1_q;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
